// File: rtl/fios_pkg.sv
// ---------------------------------------------------------------------------
// fios_pkg : shared types for the FIOS result path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fios_pkg;

  localparam int WORD_W = 17;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } collector_state_t;

endpackage

`default_nettype wire

// File: rtl/fios_word_sub.sv
// ---------------------------------------------------------------------------
// fios_word_sub : 17-bit subtract-with-borrow slice (diff = a - b - borrow_in)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fios_word_sub
  import fios_pkg::*;
(
  input  logic  [WORD_W-1:0] a,
  input  logic  [WORD_W-1:0] b,
  input  logic               borrow_in,
  output logic  [WORD_W-1:0] diff,
  output logic               borrow_out
);

  logic [WORD_W:0] wide;

  // One extra bit catches the borrow as the sign of the widened difference
  assign wide       = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, borrow_in};
  assign diff       = wide[WORD_W-1:0];
  assign borrow_out = wide[WORD_W];

endmodule

`default_nettype wire

// File: rtl/fios_res_collector.sv
// ---------------------------------------------------------------------------
// fios_res_collector : reassembles FIOS result words and applies final -p
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fios_res_collector
  import fios_pkg::*;
#(
  parameter int s         = 8,
  parameter bit FINAL_SUB = 1'b1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                res_valid_i,
  input  logic [WORD_W-1:0]   res_word_i,
  input  logic [s*WORD_W-1:0] p_full_i,
  output logic [s*WORD_W-1:0] result_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                busy_o,
  output logic                overrun_o
);

  localparam int W  = s * WORD_W;
  localparam int IW = (s > 1) ? $clog2(s) : 1;

  collector_state_t state;
  logic [IW-1:0]    idx;
  logic             borrow;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     d_acc;
  logic [W-1:0]     p_lat;
  logic [W-1:0]     result;
  logic             result_valid;
  logic             overrun;

  logic             accept;
  logic             first;
  logic             last;
  logic [IW-1:0]    cur_idx;
  word_t            sub_b;
  logic             sub_bin;
  word_t            sub_diff;
  logic             sub_bout;
  logic [W-1:0]     r_next;
  logic [W-1:0]     d_next;
  logic [W-1:0]     sel;

  // HOLD only takes a word when the held result leaves in the same cycle
  assign accept  = res_valid_i && ((state != HOLD) || result_ready_i);
  assign first   = (state != COLLECT);
  assign cur_idx = first ? '0 : idx;
  assign last    = (cur_idx == IW'(s - 1));
  // Word 0 arrives before p is latched, so it reads the modulus port directly
  assign sub_b   = first ? p_full_i[WORD_W-1:0] : p_lat[int'(cur_idx)*WORD_W +: WORD_W];
  assign sub_bin = first ? 1'b0 : borrow;

  fios_word_sub u_word_sub (
    .a          (res_word_i),
    .b          (sub_b),
    .borrow_in  (sub_bin),
    .diff       (sub_diff),
    .borrow_out (sub_bout)
  );

  always_comb begin
    r_next = r_acc;
    d_next = d_acc;
    r_next[int'(cur_idx)*WORD_W +: WORD_W] = res_word_i;
    d_next[int'(cur_idx)*WORD_W +: WORD_W] = sub_diff;
    sel = (FINAL_SUB && !sub_bout) ? d_next : r_next;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= IDLE;
      idx          <= '0;
      borrow       <= 1'b0;
      r_acc        <= '0;
      d_acc        <= '0;
      p_lat        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (result_ready_i) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end else if (res_valid_i) begin
            overrun <= 1'b1;
          end
        end
        default: ;
      endcase

      // Word acceptance overrides the HOLD->IDLE step for back-to-back results
      if (accept) begin
        r_acc  <= r_next;
        d_acc  <= d_next;
        borrow <= sub_bout;
        if (first) p_lat <= p_full_i;
        if (last) begin
          state        <= HOLD;
          idx          <= '0;
          result       <= sel;
          result_valid <= 1'b1;
        end else begin
          state <= COLLECT;
          idx   <= cur_idx + IW'(1);
        end
      end
    end
  end

  assign result_o       = result;
  assign result_valid_o = result_valid;
  assign busy_o         = (state == COLLECT);
  assign overrun_o      = overrun;

endmodule

`default_nettype wire

// File: tb/tb_fios_res_collector.sv
// ---------------------------------------------------------------------------
// tb_fios_res_collector : directed vectors for fios_res_collector (s=1,2,8)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fios_res_collector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // s=2 pair (with and without final subtraction) sharing one stream
  logic         v2 = 1'b0, rdy2 = 1'b0;
  logic [16:0]  w2 = '0;
  logic [33:0]  p2 = 34'h20005;
  logic [33:0]  res2, res2n;
  logic         rv2, rv2n, busy2, busy2n, ov2, ov2n;

  logic         v8 = 1'b0, rdy8 = 1'b0;
  logic [16:0]  w8 = '0;
  logic [135:0] p8 = '0;
  logic [135:0] res8;
  logic         rv8, busy8, ov8;

  logic         v1 = 1'b0, rdy1 = 1'b0;
  logic [16:0]  w1 = '0;
  logic [16:0]  p1 = 17'h0000F;
  logic [16:0]  res1;
  logic         rv1, busy1, ov1;

  fios_res_collector #(.s(2), .FINAL_SUB(1'b1)) dut2 (
    .clock_i(clk), .reset_i(rst), .res_valid_i(v2), .res_word_i(w2), .p_full_i(p2),
    .result_o(res2), .result_valid_o(rv2), .result_ready_i(rdy2), .busy_o(busy2), .overrun_o(ov2));

  fios_res_collector #(.s(2), .FINAL_SUB(1'b0)) dut2n (
    .clock_i(clk), .reset_i(rst), .res_valid_i(v2), .res_word_i(w2), .p_full_i(p2),
    .result_o(res2n), .result_valid_o(rv2n), .result_ready_i(rdy2), .busy_o(busy2n), .overrun_o(ov2n));

  fios_res_collector #(.s(8), .FINAL_SUB(1'b1)) dut8 (
    .clock_i(clk), .reset_i(rst), .res_valid_i(v8), .res_word_i(w8), .p_full_i(p8),
    .result_o(res8), .result_valid_o(rv8), .result_ready_i(rdy8), .busy_o(busy8), .overrun_o(ov8));

  fios_res_collector #(.s(1), .FINAL_SUB(1'b1)) dut1 (
    .clock_i(clk), .reset_i(rst), .res_valid_i(v1), .res_word_i(w1), .p_full_i(p1),
    .result_o(res1), .result_valid_o(rv1), .result_ready_i(rdy1), .busy_o(busy1), .overrun_o(ov1));

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [16:0] w0;
    logic [16:0] w1;
    int          gap;
    logic [33:0] exp_sub;
    logic [33:0] exp_raw;
  } vec_t;

  vec_t vecs[6];
  logic [135:0] r8;
  logic [135:0] exp8;

  initial begin
    vecs[0] = '{17'h00007, 17'h00001, 0, 34'h00002, 34'h20007};
    vecs[1] = '{17'h00003, 17'h00001, 0, 34'h20003, 34'h20003};
    vecs[2] = '{17'h00005, 17'h00001, 0, 34'h00000, 34'h20005};
    vecs[3] = '{17'h00004, 17'h00002, 0, 34'h1FFFF, 34'h40004};
    vecs[4] = '{17'h00007, 17'h00001, 3, 34'h00002, 34'h20007};
    vecs[5] = '{17'h00003, 17'h00001, 3, 34'h20003, 34'h20003};

    // p8 word k = k+1; R8 = p8 + (1<<119) + 2
    r8 = '0;
    for (int k = 0; k < 8; k++) p8[k*17 +: 17] = 17'(k + 1);
    for (int k = 0; k < 8; k++) r8[k*17 +: 17] = 17'(k + 1);
    r8[16:0]    = 17'h3;
    r8[135:119] = 17'h9;
    exp8 = r8 - p8;

    tick();
    tick();
    rst = 1'b0;
    chk("reset res2", res2, 0);
    chk("reset rv2", rv2, 0);
    chk("reset busy2", busy2, 0);
    chk("reset ov2", ov2, 0);
    chk("reset res8", res8, 0);
    chk("reset rv1", rv1, 0);

    for (int i = 0; i < 6; i++) begin
      v2 = 1'b1; w2 = vecs[i].w0; rdy2 = 1'b0;
      tick();
      chk($sformatf("v%0d busy after w0", i), busy2, 1);
      chk($sformatf("v%0d rv after w0", i), rv2, 0);
      for (int g = 0; g < vecs[i].gap; g++) begin
        v2 = 1'b0;
        tick();
        chk($sformatf("v%0d busy in gap", i), busy2, 1);
      end
      v2 = 1'b1; w2 = vecs[i].w1;
      tick();
      v2 = 1'b0;
      chk($sformatf("v%0d rv", i), rv2, 1);
      chk($sformatf("v%0d result sub", i), res2, vecs[i].exp_sub);
      chk($sformatf("v%0d result raw", i), res2n, vecs[i].exp_raw);
      chk($sformatf("v%0d busy in hold", i), busy2, 0);
      rdy2 = 1'b1;
      tick();
      rdy2 = 1'b0;
      chk($sformatf("v%0d rv dropped", i), rv2, 0);
    end

    // Overrun while holding, then back-to-back handshake plus new word 0
    chk("ov before", ov2, 0);
    v2 = 1'b1; w2 = 17'h7; tick();
    w2 = 17'h1; tick();
    v2 = 1'b0; tick();
    chk("hold c1 result", res2, 34'h2);
    v2 = 1'b1; w2 = 17'h1ABCD; tick();
    v2 = 1'b0;
    chk("hold c2 result", res2, 34'h2);
    chk("overrun set", ov2, 1);
    tick();
    chk("hold c3 result", res2, 34'h2);
    tick();
    chk("hold c4 result", res2, 34'h2);
    chk("hold c4 rv", rv2, 1);
    chk("overrun sticky", ov2, 1);
    v2 = 1'b1; w2 = 17'h3; rdy2 = 1'b1; tick();
    rdy2 = 1'b0;
    chk("b2b busy", busy2, 1);
    chk("b2b rv dropped", rv2, 0);
    chk("b2b overrun kept", ov2, 1);
    w2 = 17'h1; tick();
    v2 = 1'b0;
    chk("b2b rv", rv2, 1);
    chk("b2b result", res2, 34'h20003);
    rdy2 = 1'b1; tick(); rdy2 = 1'b0;

    // Reset mid-collection on s=8, then a full stream
    v8 = 1'b1; w8 = r8[16:0]; tick();
    v8 = 1'b0;
    chk("s8 busy after w0", busy8, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s8 reset busy", busy8, 0);
    chk("s8 reset rv", rv8, 0);
    chk("s8 reset result", res8, 0);
    chk("s8 reset ov", ov8, 0);
    chk("reset clears ov2", ov2, 0);
    for (int k = 0; k < 8; k++) begin
      v8 = 1'b1; w8 = r8[k*17 +: 17];
      tick();
      if (k < 7) chk($sformatf("s8 rv early w%0d", k), rv8, 0);
    end
    v8 = 1'b0;
    chk("s8 rv", rv8, 1);
    chk("s8 result", res8, exp8);
    rdy8 = 1'b1; tick(); rdy8 = 1'b0;
    chk("s8 rv dropped", rv8, 0);

    // s=1: single word goes straight to HOLD
    v1 = 1'b1; w1 = 17'h00011; tick();
    v1 = 1'b0;
    chk("s1 rv", rv1, 1);
    chk("s1 result", res1, 17'h2);
    chk("s1 busy", busy1, 0);
    v1 = 1'b1; w1 = 17'h00005; rdy1 = 1'b1; tick();
    v1 = 1'b0; rdy1 = 1'b0;
    chk("s1 b2b rv", rv1, 1);
    chk("s1 b2b result", res1, 17'h5);
    chk("s1 b2b ov", ov1, 0);
    rdy1 = 1'b1; tick(); rdy1 = 1'b0;
    chk("s1 rv dropped", rv1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
